// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: bundles the fetch unit's memory handshake, the redirect
// from decode and the (pc, inst) delivery handshake.
//   master : the fetch unit (drives o_* signals)
//   slave  : memory / decode / testbench side (drives i_* signals)
//   o_memReq/o_memAddr          fetch request and word address
//   i_memGrant                  request accepted this cycle
//   i_memValid/i_memData        in-order response word
//   i_redirect/i_redirectPc     taken branch/jump and its target
//   i_stall                     downstream cannot accept
//   o_valid/o_pc/o_inst         head instruction (zero when not valid)
interface inst_fetch_unit_if;
    logic        o_memReq;
    logic [31:0] o_memAddr;
    logic        i_memGrant;
    logic        i_memValid;
    logic [31:0] i_memData;
    logic        i_redirect;
    logic [31:0] i_redirectPc;
    logic        i_stall;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;

    modport master (
        output o_memReq, o_memAddr, o_valid, o_pc, o_inst,
        input  i_memGrant, i_memValid, i_memData, i_redirect, i_redirectPc, i_stall
    );

    modport slave (
        input  o_memReq, o_memAddr, o_valid, o_pc, o_inst,
        output i_memGrant, i_memValid, i_memData, i_redirect, i_redirectPc, i_stall
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: in-order instruction fetch front end with a small return
// buffer and MIPS single-delay-slot redirect handling.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : inst_fetch_unit_if.master (memory request/grant/response,
//            redirect from decode, valid/stall delivery of (pc, inst))
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned QD = 2 * DEPTH;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic        running;
    logic [31:0] fetch_pc,  fetch_pc_n;
    ptr_t        rd_ptr,    rd_ptr_n;
    ptr_t        wr_ptr,    wr_ptr_n;
    cnt_t        count,     count_n;
    cnt_t        inflight,  inflight_n;
    cnt_t        stale,     stale_n;
    logic        keep_next, keep_n;
    logic        pend_valid, pend_valid_n;
    logic [31:0] pend_target, pend_target_n;
    cnt_t        tag_wr, tag_rd;

    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];
    // Address of every granted request, consumed in response order. Stale
    // requests are not counted against DEPTH, so this holds twice as many.
    logic [31:0] tag_q     [QD];

    cnt_t live;
    logic mem_req, head_valid;
    logic resp, resp_drop, push, deliver, grant;

    assign live       = (inflight - stale) + count;
    // The inflight guard only keeps the counter from wrapping under a burst of
    // redirects against slow memory.
    assign mem_req    = running && (live < cnt_t'(DEPTH)) && (inflight != '1);
    assign head_valid = (count != '0);

    assign bus.o_memReq  = mem_req;
    assign bus.o_memAddr = fetch_pc;
    assign bus.o_valid   = head_valid;
    assign bus.o_pc      = head_valid ? fifo_pc[rd_ptr]   : '0;
    assign bus.o_inst    = head_valid ? fifo_inst[rd_ptr] : '0;

    always_comb begin
        resp      = bus.i_memValid;
        // keep_next marks the oldest in-flight word as a delay slot that must
        // survive even though younger in-flight words are being discarded.
        resp_drop = resp && !keep_next && (stale != '0);
        push      = resp && !resp_drop;
        deliver   = head_valid && !bus.i_stall;
        grant     = mem_req && bus.i_memGrant;

        inflight_n    = inflight - cnt_t'(resp) + cnt_t'(grant);
        stale_n       = stale - cnt_t'(resp_drop);
        keep_n        = keep_next && !resp;
        count_n       = count + cnt_t'(push) - cnt_t'(deliver);
        rd_ptr_n      = rd_ptr + ptr_t'(deliver);
        wr_ptr_n      = wr_ptr + ptr_t'(push);
        fetch_pc_n    = fetch_pc;
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;

        if (grant) begin
            if (pend_valid) begin
                fetch_pc_n   = pend_target;
                pend_valid_n = 1'b0;
            end else begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
        end

        // Redirect is evaluated after this cycle's response, delivery and grant.
        if (bus.i_redirect) begin
            if (deliver) begin
                count_n    = '0;
                wr_ptr_n   = rd_ptr_n;
                stale_n    = inflight_n;
                keep_n     = 1'b0;
                fetch_pc_n = bus.i_redirectPc;
            end else if (count_n != '0) begin
                count_n    = cnt_t'(1);
                wr_ptr_n   = rd_ptr + ptr_t'(1);
                stale_n    = inflight_n;
                keep_n     = 1'b0;
                fetch_pc_n = bus.i_redirectPc;
            end else if (inflight_n != '0) begin
                stale_n    = inflight_n - cnt_t'(1);
                keep_n     = 1'b1;
                fetch_pc_n = bus.i_redirectPc;
            end else begin
                pend_valid_n  = 1'b1;
                pend_target_n = bus.i_redirectPc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= '0;
            stale       <= '0;
            keep_next   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            running     <= 1'b1;
            fetch_pc    <= fetch_pc_n;
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            count       <= count_n;
            inflight    <= inflight_n;
            stale       <= stale_n;
            keep_next   <= keep_n;
            pend_valid  <= pend_valid_n;
            pend_target <= pend_target_n;
            tag_wr      <= tag_wr + cnt_t'(grant);
            tag_rd      <= tag_rd + cnt_t'(resp);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
            fifo_inst[wr_ptr] <= bus.i_memData;
        end
        if (grant) begin
            tag_q[tag_wr] <= fetch_pc;
        end
    end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front end that produces the `(pc, inst)` stream consumed by the decode stage, and honours decode's branch/jump redirects (`takeBranch`/`jpc`) with MIPS single-delay-slot semantics. It issues in-order word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. It delivers instructions downstream under a valid/stall handshake.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default `4`: buffer entries, power of two ≥ 2. It also bounds in-flight plus buffered words.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `o_memReq`  out  1  fetch request valid.
- `o_memAddr`  out  32  word-aligned fetch address.
- `i_memGrant`  in  1  request accepted this cycle; meaningful only with `o_memReq`.
- `i_memValid`  in  1  response word valid. Responses return in request order, ≥1 cycle after grant.
- `i_memData`  in  32  response instruction word.
- `i_redirect`  in  1  branch/jump taken, driven from decode `takeBranch`.
- `i_redirectPc`  in  32  target, driven from decode `jpc`.
- `i_stall`  in  1  downstream cannot accept.
- `o_valid`  out  1  head instruction valid.
- `o_pc`  out  32  head instruction address; 0 when `o_valid`=0.
- `o_inst`  out  32  head instruction word; 0 when `o_valid`=0.

## Operation
- State:
  - `fetchPc`: next address to request.
  - FIFO of `{pc,inst}` with count.
  - `inflight`: granted, unreturned requests, counter width log2(DEPTH)+1.
  - `stale`: in-flight responses to discard, ≤ `inflight`.
  - `pendTarget` valid + 32-bit register.
  - A pc queue, or a per-request pc derivation, tagging each response with its address.
- Request:
  - `o_memReq` = 1 iff out of reset and (`inflight` − `stale`) + count < `DEPTH`.
  - `o_memAddr` = `fetchPc`.
  - On grant: `inflight`++, `fetchPc` += 4 (mod 2^32, wraps `FFFF_FFFC`→0).
  - If `pendTarget` is valid on grant: `fetchPc` ← target and `pendTarget` clears.
- Response: if `stale`>0, drop the word and decrement `stale`. Otherwise push `{pc, i_memData}`. Either way, `inflight`--.
- Delivery: transfer occurs when `o_valid` & ~`i_stall`; pop the head.
- Redirect. Events within a cycle are ordered: response, delivery, grant, redirect. The delay slot is the oldest instruction not yet delivered before this cycle.
  - Delivery occurred this cycle: that delivered word is the slot. Flush the FIFO, set `stale` = `inflight`, `fetchPc` ← target.
  - FIFO non-empty: keep the head only. Flush the rest, set `stale` = `inflight`, `fetchPc` ← target.
  - FIFO empty, `inflight`>0: keep the first in-flight response. Set `stale` = `inflight`−1, `fetchPc` ← target.
  - Nothing fetched: the slot is at `fetchPc`. Load `pendTarget`; the next granted request fetches the slot, then the target.
- An ungranted request is not in flight; its address may change after a redirect.
- A second redirect while `pendTarget` is valid is illegal input; behaviour is unspecified.

## Timing
- Reset (async, `rst_n`=0): `o_memReq`=0, `o_valid`=0, `o_pc`=0, `o_inst`=0, `fetchPc`=`RESET_PC`, all counters 0, `pendTarget` invalid.
- First request is in the first cycle after `rst_n` rises.
- `o_memReq`/`o_memAddr` are functions of registered state only; there is no combinational path from `i_memGrant`, `i_stall`, or `i_redirect`.
- `o_valid`/`o_pc`/`o_inst` are registered (FIFO head). A response is visible one cycle after `i_memValid`.
- Redirect takes effect on `o_memAddr` in the following cycle.
- With 1-cycle memory and no stall, `DEPTH`=4 sustains 1 instruction/cycle.
- Reset mid-operation drops everything instantly. Responses to pre-reset requests must not be sent by memory; they are memory's responsibility.

## Test plan
- Reset: `rst_n`=0 for 3 cycles → all outputs 0. Release → next cycle `o_memReq`=1, `o_memAddr`=0.
- Streaming with 1-cycle memory (`inst` = `pc`^`32'hA5A5A5A5`), `i_stall`=0 → `o_pc` = 0,4,8,… on consecutive cycles, words match, no gaps after fill.
- Backpressure: `i_stall`=1 for 10 cycles → `o_memReq` deasserts after 4 outstanding+buffered and `o_pc` holds. Release → sequence continues with no loss or duplicate.
- Redirect, buffered: FIFO holds 0x10,0x14,0x18, `i_stall`=1, redirect to 0x100 → deliveries are 0x10, 0x100, 0x104. `o_memAddr`=0x100 next cycle.
- Redirect, in flight: 3-cycle memory, 3 requests 0x20..0x28 in flight, FIFO empty, redirect to 0x300 → 0x20 delivered, 0x24/0x28 discarded, then 0x300.
- Redirect, nothing fetched: memory withholds grant, redirect to 0x200 while `fetchPc`=0x40 → requests 0x40 then 0x200. Async reset asserted mid-stream → outputs 0 immediately, restart at `RESET_PC`.
